// File: rtl/ifetch_queue_if.sv
// rtl/ifetch_queue_if.sv - fetch queue bus: SRAM request/response, redirect and consumer side
interface ifetch_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   boot_addr;
  logic          redirect;
  logic [31:0]   redirect_pc;
  logic          lr_isram_cs;
  logic          isram_cs;
  logic [28:0]   isram_adr;
  logic [63:0]   instr_fromsram;
  logic          deq;
  logic          q_valid;
  logic [28:0]   q_adr;
  logic [63:0]   q_data;
  logic          q_valid_nxt;
  logic [63:0]   q_data_nxt;
  logic [CW-1:0] q_count;

  // queue side
  modport slave (
    input  boot_addr, redirect, redirect_pc, lr_isram_cs, instr_fromsram, deq,
    output isram_cs, isram_adr, q_valid, q_adr, q_data, q_valid_nxt, q_data_nxt, q_count
  );

  // environment side (SRAM, redirect source, extraction logic)
  modport master (
    output boot_addr, redirect, redirect_pc, lr_isram_cs, instr_fromsram, deq,
    input  isram_cs, isram_adr, q_valid, q_adr, q_data, q_valid_nxt, q_data_nxt, q_count
  );
endinterface

// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - instruction prefetch queue of 64-bit lines with head/next exposure
module ifetch_queue #(
  parameter int DEPTH = 4
) (
  input logic           clk,
  input logic           cpurst,
  ifetch_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [28:0]   fadr;
  logic          inflight;
  logic [28:0]   adr_inflight;
  logic [28:0]   mem_adr  [DEPTH];
  logic [63:0]   mem_data [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW-1:0] head_nxt;
  logic [CW-1:0] count;
  logic [CW:0]   occupancy;
  logic          issue;
  logic          push;
  logic          pop;

  // Low address bits select within a line and are not needed here.
  logic unused_low_bits;
  assign unused_low_bits = ^{bus.boot_addr[2:0], bus.redirect_pc[2:0]};

  // Request/credit decision; an outstanding read already owns a slot, and a
  // same-cycle deq earns no credit so the path stays short.
  always_comb begin
    occupancy = {1'b0, count} + {{CW{1'b0}}, inflight};
    issue     = !cpurst && !bus.redirect && !bus.lr_isram_cs &&
                (occupancy < (CW+1)'(DEPTH));
    push      = inflight && !bus.redirect;
    pop       = bus.deq && (count != '0) && !bus.redirect;
    head_nxt  = head + 1'b1;
  end

  assign bus.isram_cs    = issue;
  assign bus.isram_adr   = fadr;
  assign bus.q_valid     = !cpurst && (count != '0);
  assign bus.q_valid_nxt = !cpurst && (count >= CW'(2));
  assign bus.q_count     = cpurst ? '0 : count;
  assign bus.q_adr       = mem_adr[head];
  assign bus.q_data      = mem_data[head];
  assign bus.q_data_nxt  = mem_data[head_nxt];

  // Fetch address, outstanding-read tracking and queue storage; redirect
  // flushes everything and drops the response arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (cpurst) begin
      fadr         <= bus.boot_addr[31:3];
      inflight     <= 1'b0;
      adr_inflight <= '0;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
    end else if (bus.redirect) begin
      fadr     <= bus.redirect_pc[31:3];
      inflight <= 1'b0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        fadr         <= fadr + 29'd1;
        adr_inflight <= fadr;
      end
      if (push) begin
        mem_adr[tail]  <= adr_inflight;
        mem_data[tail] <= bus.instr_fromsram;
        tail           <= tail + 1'b1;
      end
      if (pop) begin
        head <= head_nxt;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Instruction prefetch queue between the 64-bit instruction SRAM and the rv32/rv16 extraction logic of the fetch stage.
- Issues sequential 64-bit line reads ahead of consumption and buffers up to DEPTH lines with their addresses.
- Exposes the head line and the following line, so instructions crossing a 64-bit boundary can be assembled in one cycle.
- Yields the SRAM port to load/store accesses and restarts cleanly on redirect (branch mispredict, trap, mret).

Parameters:
DEPTH, 4, number of 64-bit line entries (power of 2, minimum 2)

Ports:
clk  input  1  clock
cpurst  input  1  synchronous active-high reset
boot_addr  input  32  reset fetch address; bits [31:3] used
redirect  input  1  flush queue and restart fetching at redirect_pc
redirect_pc  input  32  new fetch address; bits [31:3] used
lr_isram_cs  input  1  load/store owns the SRAM this cycle
isram_cs  output  1  SRAM read request
isram_adr  output  29  SRAM line address [31:3]
instr_fromsram  input  64  SRAM read data, valid the cycle after isram_cs
deq  input  1  pop head entry
q_valid  output  1  head entry valid
q_adr  output  29  head line address [31:3]
q_data  output  64  head line data
q_valid_nxt  output  1  second entry valid
q_data_nxt  output  64  second entry data
q_count  output  log2(DEPTH)+1  occupied entries

Behaviour:
- Reset (cpurst high at posedge):
  - fadr <= boot_addr[31:3]; queue empty; inflight <= 0.
  - Outputs while in reset: q_valid=0, q_valid_nxt=0, q_count=0, isram_cs=0.
  - First request is issued in the first cycle with cpurst low.
- Request (combinational):
  - isram_cs = !cpurst & !redirect & !lr_isram_cs & (q_count + inflight < DEPTH).
  - isram_adr = fadr.
  - A pending deq gives no credit in the same cycle.
- On an issue cycle:
  - fadr <= fadr + 1, modulo 2^29 (0x1FFFFFFF wraps to 0).
  - inflight <= 1; adr_inflight <= fadr.
  - On a cycle with no issue: inflight <= 0.
- Response: if inflight=1 and redirect=0, push {adr_inflight, instr_fromsram} at the tail. Capture is unconditional on lr_isram_cs, because the data was read in the previous cycle.
- Latency: request at cycle t -> q_valid=1 at t+2 when the queue was empty.
- Steady-state throughput: 1 line/cycle when not blocked.
- Dequeue:
  - deq with q_valid=1 removes the head.
  - deq with q_valid=0 is ignored; no underflow, count stays 0.
- Simultaneous push and deq: count unchanged; the new entry lands behind the remaining ones.
- Full: q_count=DEPTH only when inflight was counted, so a push never meets a full queue. Overflow is impossible by construction.
- Outputs q_adr/q_data/q_data_nxt:
  - Read combinationally from head and head+1 pointers; pointers wrap modulo DEPTH.
  - q_valid_nxt = (q_count >= 2).
  - Contents are don't-care when the matching valid is 0.
- Redirect (priority over deq, push, request):
  - Same cycle: isram_cs=0; any arriving response is dropped.
  - Next edge: queue emptied (head=tail, count=0), inflight <= 0, fadr <= redirect_pc[31:3].
  - Next cycle: requests resume from redirect_pc.
  - Back-to-back redirects: the last one wins.
- lr_isram_cs high: no request that cycle; fadr and queue are held except for pending response and deq. Fetching resumes the cycle lr_isram_cs drops.
- Reset mid-operation: same as power-on reset regardless of queue state or inflight.

Test Plan:
1. Reset with boot_addr=0x8000_0000, deq=0 → requests at adr 0x1000_0000..0x1000_0003 in 4 consecutive cycles, then isram_cs=0; q_count=4; q_adr=0x1000_0000.
2. Steady stream with deq held 1 and SRAM returning data=adr → one isram_cs per cycle, adr incrementing by 1; q_data[28:0] equals q_adr every valid cycle; q_count stays 1.
3. Queue holds 3 entries, inflight=1, redirect with redirect_pc=0x0000_0104 → the arriving response is dropped, q_valid=0 next cycle, next request adr=0x20, and q_valid=1 with q_adr=0x20 two cycles later.
4. lr_isram_cs high for 3 cycles during streaming → isram_cs=0 for exactly those 3 cycles; the response of the request issued just before is still queued; no line is lost or duplicated.
5. boot_addr=0xFFFF_FFF8 → request adrs 0x1FFFFFFF then 0x0000000; both queued in order.
6. deq on an empty queue, and deq together with push at q_count=1 → count stays 0 in the first case and 1 in the second; q_valid_nxt=1 only when q_count>=2; the head advances correctly.
